// File: rtl/dca_mlsu_arb_pkg.sv
// Shared state encoding and sizing helpers for the MLSU instruction arbiter.
// The instruction width default is overridden through the BW_INST parameter at integration.
package dca_mlsu_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_EXEC  = 2'd2
    } arb_state_e;

    localparam int DCA_BW_INST_DEFAULT = 32;

    function automatic int BW_REQ_ID(input int numReq);
        return (numReq > 1) ? $clog2(numReq) : 1;
    endfunction

endpackage

// File: rtl/dca_mlsu_inst_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr_i,
// wrapping around to bit 0.
module dca_rr_pick
    import dca_mlsu_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int W       = BW_REQ_ID(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [W-1:0]       ptr_i,
    output logic               found_o,
    output logic [W-1:0]       idx_o
);

    logic [2*NUM_REQ-1:0] reqDouble;
    logic [NUM_REQ-1:0]   reqRot;
    int                   pos;

    // Rotating a doubled copy puts the pointer at bit 0, so the lowest set bit is the winner.
    always_comb begin
        reqDouble = {req_i, req_i};
        reqRot    = NUM_REQ'(reqDouble >> ptr_i);
        found_o   = 1'b0;
        pos       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (reqRot[k]) begin
                found_o = 1'b1;
                pos     = k;
            end
        end
        pos = pos + int'(ptr_i);
        if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
        end
        idx_o = W'(pos);
    end

endmodule

// File: rtl/dca_mlsu_inst_arbiter.sv
// Round-robin arbiter sharing one MLSU between NUM_REQ instruction requesters.
// Define DCA_MLSU_ARB_WATCHDOG_EN to add the EXEC timeout and the wdog_error port.
module dca_mlsu_inst_arbiter
    import dca_mlsu_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int BW_INST     = DCA_BW_INST_DEFAULT,
    parameter int BW_ROW      = 128,
    parameter int WDOG_CYCLES = 4096,
    localparam int W          = BW_REQ_ID(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rstnn,
    input  logic [NUM_REQ-1:0]         req_inst_wvalid,
    input  logic [NUM_REQ*BW_INST-1:0] req_inst_wdata,
    output logic [NUM_REQ-1:0]         req_inst_wready,
    output logic [NUM_REQ-1:0]         req_decode_finish,
    output logic [NUM_REQ-1:0]         req_execute_finish,
    output logic [NUM_REQ-1:0]         req_busy,
    output logic [NUM_REQ-1:0]         req_load_row_wvalid,
    output logic [NUM_REQ-1:0]         req_load_row_wlast,
    output logic [BW_ROW-1:0]          req_load_row_wdata,
    input  logic [NUM_REQ-1:0]         req_load_row_wready,
    output logic [NUM_REQ-1:0]         req_store_row_rvalid,
    output logic [NUM_REQ-1:0]         req_store_row_rlast,
    input  logic [NUM_REQ-1:0]         req_store_row_rready,
    input  logic [NUM_REQ*BW_ROW-1:0]  req_store_row_rdata,
    output logic                       msinst_wvalid,
    output logic [BW_INST-1:0]         msinst_wdata,
    input  logic                       msinst_wready,
    input  logic                       msinst_decode_finish,
    input  logic                       msinst_execute_finish,
    input  logic                       msinst_busy,
    input  logic                       msload_row_wvalid,
    input  logic                       msload_row_wlast,
    input  logic [BW_ROW-1:0]          msload_row_wdata,
    output logic                       msload_row_wready,
    input  logic                       msstore_row_rvalid,
    input  logic                       msstore_row_rlast,
    output logic                       msstore_row_rready,
    output logic [BW_ROW-1:0]          msstore_row_rdata,
    output logic [W-1:0]               grant_id,
    output logic                       arb_active
`ifdef DCA_MLSU_ARB_WATCHDOG_EN
    ,
    output logic                       wdog_error
`endif
);

    arb_state_e   state_q, state_d;
    logic [W-1:0] owner_q, owner_d;
    logic [W-1:0] rrPtr_q, rrPtr_d;
    logic         pickFound;
    logic [W-1:0] pickIdx;
    logic         ownerActive;
    logic         wdogExpire;

    dca_rr_pick #(
        .NUM_REQ(NUM_REQ),
        .W      (W)
    ) u_pick (
        .req_i  (req_inst_wvalid),
        .ptr_i  (rrPtr_q),
        .found_o(pickFound),
        .idx_o  (pickIdx)
    );

    assign ownerActive = (state_q != ARB_IDLE);
    assign arb_active  = ownerActive;
    assign grant_id    = owner_q;

    // Owner mux: while a grant is held every channel connects only to the owner's bit.
    always_comb begin
        req_inst_wready      = '0;
        req_decode_finish    = '0;
        req_execute_finish   = '0;
        req_busy             = '0;
        req_load_row_wvalid  = '0;
        req_load_row_wlast   = '0;
        req_store_row_rvalid = '0;
        req_store_row_rlast  = '0;
        msinst_wvalid        = 1'b0;
        msinst_wdata         = '0;
        msload_row_wready    = 1'b0;
        msstore_row_rready   = 1'b0;
        msstore_row_rdata    = '0;
        req_load_row_wdata   = ownerActive ? msload_row_wdata : '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ownerActive && (owner_q == W'(i))) begin
                req_decode_finish[i]    = msinst_decode_finish;
                req_execute_finish[i]   = msinst_execute_finish;
                req_busy[i]             = msinst_busy;
                req_load_row_wvalid[i]  = msload_row_wvalid;
                req_load_row_wlast[i]   = msload_row_wlast;
                req_store_row_rvalid[i] = msstore_row_rvalid;
                req_store_row_rlast[i]  = msstore_row_rlast;
                msload_row_wready       = req_load_row_wready[i];
                msstore_row_rready      = req_store_row_rready[i];
                msstore_row_rdata       = req_store_row_rdata[i*BW_ROW +: BW_ROW];
                if (state_q == ARB_ISSUE) begin
                    msinst_wvalid      = req_inst_wvalid[i];
                    msinst_wdata       = req_inst_wdata[i*BW_INST +: BW_INST];
                    req_inst_wready[i] = msinst_wready;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rrPtr_d = rrPtr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pickFound) begin
                    state_d = ARB_ISSUE;
                    owner_d = pickIdx;
                    rrPtr_d = (pickIdx == W'(NUM_REQ - 1)) ? '0 : pickIdx + 1'b1;
                end
            end
            ARB_ISSUE: begin
                if (msinst_wvalid && msinst_wready) begin
                    state_d = msinst_execute_finish ? ARB_IDLE : ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                if (msinst_execute_finish || wdogExpire) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstnn) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            rrPtr_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rrPtr_q <= rrPtr_d;
        end
    end

`ifdef DCA_MLSU_ARB_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdogCnt_q, wdogCnt_d;
    logic              wdogErr_q, wdogErr_d;

    // Counter only runs in EXEC, so it restarts from zero on every EXEC entry.
    assign wdogExpire = (state_q == ARB_EXEC) && !msinst_execute_finish
                        && (wdogCnt_q == WDOG_W'(WDOG_CYCLES - 1));
    assign wdog_error = wdogErr_q;

    always_comb begin
        wdogErr_d = wdogErr_q | wdogExpire;
        wdogCnt_d = (state_q == ARB_EXEC) ? wdogCnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rstnn) begin
            wdogCnt_q <= '0;
            wdogErr_q <= 1'b0;
        end else begin
            wdogCnt_q <= wdogCnt_d;
            wdogErr_q <= wdogErr_d;
        end
    end
`else
    assign wdogExpire = 1'b0;
`endif

endmodule

// File: tb/tb_dca_mlsu_inst_arbiter.sv
// Self-checking bench for dca_mlsu_inst_arbiter with a round-robin reference model.
// The watchdog scenario runs only when DCA_MLSU_ARB_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_dca_mlsu_inst_arbiter;

    localparam int NUM_REQ     = 3;
    localparam int BW_INST     = 32;
    localparam int BW_ROW      = 128;
    localparam int WDOG_CYCLES = 16;
    localparam int W           = 2;
    localparam int OUT_W       = 8*NUM_REQ + 2*BW_ROW + BW_INST + 3;

    logic                       clk;
    logic                       rstnn;
    logic [NUM_REQ-1:0]         req_inst_wvalid;
    logic [NUM_REQ*BW_INST-1:0] req_inst_wdata;
    logic [NUM_REQ-1:0]         req_inst_wready;
    logic [NUM_REQ-1:0]         req_decode_finish;
    logic [NUM_REQ-1:0]         req_execute_finish;
    logic [NUM_REQ-1:0]         req_busy;
    logic [NUM_REQ-1:0]         req_load_row_wvalid;
    logic [NUM_REQ-1:0]         req_load_row_wlast;
    logic [BW_ROW-1:0]          req_load_row_wdata;
    logic [NUM_REQ-1:0]         req_load_row_wready;
    logic [NUM_REQ-1:0]         req_store_row_rvalid;
    logic [NUM_REQ-1:0]         req_store_row_rlast;
    logic [NUM_REQ-1:0]         req_store_row_rready;
    logic [NUM_REQ*BW_ROW-1:0]  req_store_row_rdata;
    logic                       msinst_wvalid;
    logic [BW_INST-1:0]         msinst_wdata;
    logic                       msinst_wready;
    logic                       msinst_decode_finish;
    logic                       msinst_execute_finish;
    logic                       msinst_busy;
    logic                       msload_row_wvalid;
    logic                       msload_row_wlast;
    logic [BW_ROW-1:0]          msload_row_wdata;
    logic                       msload_row_wready;
    logic                       msstore_row_rvalid;
    logic                       msstore_row_rlast;
    logic                       msstore_row_rready;
    logic [BW_ROW-1:0]          msstore_row_rdata;
    logic [W-1:0]               grant_id;
    logic                       arb_active;
`ifdef DCA_MLSU_ARB_WATCHDOG_EN
    logic                       wdog_error;
`endif

    int                 assertCount = 0;
    int                 failCount   = 0;
    int                 modelPtr    = 0;
    logic [BW_INST-1:0] curInst [NUM_REQ];
    logic [OUT_W-1:0]   outBus;

    dca_mlsu_inst_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .BW_INST    (BW_INST),
        .BW_ROW     (BW_ROW),
        .WDOG_CYCLES(WDOG_CYCLES)
    ) dut (
        .clk                  (clk),
        .rstnn                (rstnn),
        .req_inst_wvalid      (req_inst_wvalid),
        .req_inst_wdata       (req_inst_wdata),
        .req_inst_wready      (req_inst_wready),
        .req_decode_finish    (req_decode_finish),
        .req_execute_finish   (req_execute_finish),
        .req_busy             (req_busy),
        .req_load_row_wvalid  (req_load_row_wvalid),
        .req_load_row_wlast   (req_load_row_wlast),
        .req_load_row_wdata   (req_load_row_wdata),
        .req_load_row_wready  (req_load_row_wready),
        .req_store_row_rvalid (req_store_row_rvalid),
        .req_store_row_rlast  (req_store_row_rlast),
        .req_store_row_rready (req_store_row_rready),
        .req_store_row_rdata  (req_store_row_rdata),
        .msinst_wvalid        (msinst_wvalid),
        .msinst_wdata         (msinst_wdata),
        .msinst_wready        (msinst_wready),
        .msinst_decode_finish (msinst_decode_finish),
        .msinst_execute_finish(msinst_execute_finish),
        .msinst_busy          (msinst_busy),
        .msload_row_wvalid    (msload_row_wvalid),
        .msload_row_wlast     (msload_row_wlast),
        .msload_row_wdata     (msload_row_wdata),
        .msload_row_wready    (msload_row_wready),
        .msstore_row_rvalid   (msstore_row_rvalid),
        .msstore_row_rlast    (msstore_row_rlast),
        .msstore_row_rready   (msstore_row_rready),
        .msstore_row_rdata    (msstore_row_rdata),
        .grant_id             (grant_id),
        .arb_active           (arb_active)
`ifdef DCA_MLSU_ARB_WATCHDOG_EN
        ,
        .wdog_error           (wdog_error)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requesters always present their current pending instruction on their slice.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_inst_wdata[i*BW_INST +: BW_INST] = curInst[i];
        end
    end

    assign outBus = {req_inst_wready, req_decode_finish, req_execute_finish, req_busy,
                     req_load_row_wvalid, req_load_row_wlast, req_load_row_wdata,
                     req_store_row_rvalid, req_store_row_rlast, msinst_wvalid, msinst_wdata,
                     msload_row_wready, msstore_row_rready, msstore_row_rdata};

    // Round-robin rule: first requester at or after the pointer, wrapping around.
    function automatic int modelPick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic doReset();
        @(negedge clk);
        rstnn                 = 1'b1;
        req_inst_wvalid       = '0;
        req_load_row_wready   = '0;
        req_store_row_rready  = '0;
        req_store_row_rdata   = '0;
        msinst_wready         = 1'b0;
        msinst_decode_finish  = 1'b0;
        msinst_execute_finish = 1'b0;
        msinst_busy           = 1'b0;
        msload_row_wvalid     = 1'b0;
        msload_row_wlast      = 1'b0;
        msload_row_wdata      = '0;
        msstore_row_rvalid    = 1'b0;
        msstore_row_rlast     = 1'b0;
        repeat (2) @(negedge clk);
        rstnn    = 1'b0;
        modelPtr = 0;
        #1;
    endtask

    // Raises requests now, waits for the ISSUE phase and completes the handshake.
    task automatic startTransaction(input logic [NUM_REQ-1:0] valids, input logic keepValid,
                                    output int winner);
        int waited;
        winner   = modelPick(valids, modelPtr);
        modelPtr = (winner + 1) % NUM_REQ;
        req_inst_wvalid = valids;
        msinst_wready   = 1'b1;
        #1;
        waited = 0;
        while (msinst_wvalid !== 1'b1 && waited < 8) begin
            @(negedge clk);
            #1;
            waited++;
        end
        assertCount++;
        if (waited != 1) begin
            failCount++;
            $display("[TB] FAIL grant_latency: got %0d cycles, expected 1", waited);
        end
        assertCount++;
        if (grant_id !== W'(winner)) begin
            failCount++;
            $display("[TB] FAIL grant_id: got %0d expected %0d", grant_id, winner);
        end
        assertCount++;
        if (msinst_wdata !== curInst[winner]) begin
            failCount++;
            $display("[TB] FAIL inst_data: got %h expected %h", msinst_wdata, curInst[winner]);
        end
        assertCount++;
        if (req_inst_wready !== (NUM_REQ'(1) << winner)) begin
            failCount++;
            $display("[TB] FAIL inst_wready: got %b expected %b", req_inst_wready,
                     NUM_REQ'(1) << winner);
        end
        @(negedge clk);
        if (!keepValid) req_inst_wvalid[winner] = 1'b0;
        curInst[winner] = $urandom;
        msinst_wready   = 1'b0;
        #1;
    endtask

    task automatic endTransaction();
        msinst_execute_finish = 1'b1;
        @(negedge clk);
        msinst_execute_finish = 1'b0;
        #1;
        assertCount++;
        if (arb_active !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL return_idle: arb_active got %b expected 0", arb_active);
        end
    endtask

    task automatic test_reset();
        doReset();
        msinst_busy         = 1'b1;
        msload_row_wvalid   = 1'b1;
        msload_row_wdata    = {$urandom, $urandom, $urandom, $urandom};
        msstore_row_rvalid  = 1'b1;
        req_store_row_rready = '1;
        req_load_row_wready  = '1;
        req_store_row_rdata  = {12{$urandom}};
        #1;
        assertCount++;
        if (outBus !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", outBus);
        end
        assertCount++;
        if ({arb_active, grant_id} !== 3'b000) begin
            failCount++;
            $display("[TB] FAIL reset_state: got active=%b grant=%0d expected 0/0", arb_active, grant_id);
        end
`ifdef DCA_MLSU_ARB_WATCHDOG_EN
        assertCount++;
        if (wdog_error !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_wdog: got %b expected 0", wdog_error);
        end
`endif
    endtask

    task automatic test_single();
        int w;
        int pulses;
        doReset();
        curInst[1] = 32'h5A;
        startTransaction(3'b010, 1'b0, w);
        assertCount++;
        if (arb_active !== 1'b1 || msinst_wvalid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL single_exec: got active=%b wvalid=%b expected 1/0", arb_active, msinst_wvalid);
        end
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            msinst_busy           = 1'b1;
            msinst_decode_finish  = (c == 0);
            msinst_execute_finish = (c == 9);
            #1;
            assertCount++;
            if (req_busy !== 3'b010 || req_decode_finish !== (c == 0 ? 3'b010 : 3'b000)) begin
                failCount++;
                $display("[TB] FAIL single_status: got busy=%b dec=%b cycle %0d", req_busy, req_decode_finish, c);
            end
            if (req_execute_finish === 3'b010) pulses++;
            @(negedge clk);
        end
        msinst_busy           = 1'b0;
        msinst_decode_finish  = 1'b0;
        msinst_execute_finish = 1'b0;
        #1;
        assertCount++;
        if (pulses != 1) begin
            failCount++;
            $display("[TB] FAIL single_finish_pulse: got %0d pulses expected 1", pulses);
        end
        assertCount++;
        if (arb_active !== 1'b0 || grant_id !== 2'd1 || req_busy !== 3'b000) begin
            failCount++;
            $display("[TB] FAIL single_idle: got active=%b grant=%0d busy=%b expected 0/1/000",
                     arb_active, grant_id, req_busy);
        end
    endtask

    task automatic test_round_robin();
        int w;
        doReset();
        for (int i = 0; i < NUM_REQ; i++) curInst[i] = $urandom;
        for (int g = 0; g < 6; g++) begin
            startTransaction('1, 1'b1, w);
            assertCount++;
            if (grant_id !== W'(g % NUM_REQ)) begin
                failCount++;
                $display("[TB] FAIL rr_order: grant %0d got %0d expected %0d", g, grant_id, g % NUM_REQ);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #1;
            endTransaction();
        end
        req_inst_wvalid = '0;
    endtask

    task automatic test_load_rows();
        logic [BW_ROW-1:0] rows [8];
        int w;
        int k;
        int ownerBeats;
        int lastAt;
        doReset();
        for (int i = 0; i < 8; i++) rows[i] = {$urandom, $urandom, $urandom, $urandom};
        startTransaction(3'b100, 1'b0, w);
        k = 0;
        ownerBeats = 0;
        lastAt = -1;
        for (int cyc = 0; cyc < 200 && k < 8; cyc++) begin
            msload_row_wvalid   = ($urandom_range(0, 3) != 0);
            msload_row_wlast    = (k == 7);
            msload_row_wdata    = rows[k];
            req_load_row_wready = NUM_REQ'($urandom_range(0, 7));
            #1;
            assertCount++;
            if (req_load_row_wvalid !== {msload_row_wvalid, 2'b00}
                || req_load_row_wlast !== {msload_row_wlast, 2'b00}) begin
                failCount++;
                $display("[TB] FAIL load_route: got valid=%b last=%b row %0d", req_load_row_wvalid,
                         req_load_row_wlast, k);
            end
            assertCount++;
            if (msload_row_wready !== req_load_row_wready[2]) begin
                failCount++;
                $display("[TB] FAIL load_ready: got %b expected %b", msload_row_wready, req_load_row_wready[2]);
            end
            if (msload_row_wvalid) begin
                assertCount++;
                if (req_load_row_wdata !== rows[k]) begin
                    failCount++;
                    $display("[TB] FAIL load_data: got %h expected %h", req_load_row_wdata, rows[k]);
                end
            end
            if (req_load_row_wvalid[2] && req_load_row_wready[2]) begin
                ownerBeats++;
                if (req_load_row_wlast[2]) lastAt = ownerBeats;
            end
            if (msload_row_wvalid && req_load_row_wready[2]) k++;
            @(negedge clk);
        end
        msload_row_wvalid   = 1'b0;
        msload_row_wlast    = 1'b0;
        req_load_row_wready = '0;
        #1;
        assertCount++;
        if (ownerBeats != 8 || lastAt != 8) begin
            failCount++;
            $display("[TB] FAIL load_beats: got %0d beats last at %0d expected 8/8", ownerBeats, lastAt);
        end
        endTransaction();
    endtask

    task automatic test_store_rows();
        logic [BW_ROW-1:0] rows [4];
        int w;
        int k;
        int accepted;
        doReset();
        rows[0] = 128'h11;
        rows[1] = 128'h22;
        rows[2] = 128'h33;
        rows[3] = 128'h44;
        startTransaction(3'b001, 1'b0, w);
        k = 0;
        accepted = 0;
        for (int cyc = 0; cyc < 200 && k < 4; cyc++) begin
            msstore_row_rvalid   = ($urandom_range(0, 3) != 0);
            msstore_row_rlast    = (k == 3);
            req_store_row_rready = NUM_REQ'($urandom_range(0, 7));
            req_store_row_rdata  = {{4{$urandom}}, {4{$urandom}}, rows[k]};
            #1;
            assertCount++;
            if (req_store_row_rvalid !== {2'b00, msstore_row_rvalid}
                || req_store_row_rlast !== {2'b00, msstore_row_rlast}) begin
                failCount++;
                $display("[TB] FAIL store_route: got valid=%b last=%b row %0d", req_store_row_rvalid,
                         req_store_row_rlast, k);
            end
            assertCount++;
            if (msstore_row_rready !== req_store_row_rready[0]) begin
                failCount++;
                $display("[TB] FAIL store_ready: got %b expected %b", msstore_row_rready, req_store_row_rready[0]);
            end
            assertCount++;
            if (msstore_row_rdata !== rows[k]) begin
                failCount++;
                $display("[TB] FAIL store_data: got %h expected %h", msstore_row_rdata, rows[k]);
            end
            if (msstore_row_rvalid && msstore_row_rready) accepted++;
            if (msstore_row_rvalid && req_store_row_rready[0]) k++;
            @(negedge clk);
        end
        msstore_row_rvalid   = 1'b0;
        msstore_row_rlast    = 1'b0;
        req_store_row_rready = '0;
        #1;
        assertCount++;
        if (accepted != 4) begin
            failCount++;
            $display("[TB] FAIL store_beats: got %0d expected 4", accepted);
        end
        endTransaction();
    endtask

    task automatic test_finish_in_handshake();
        int w;
        doReset();
        w        = modelPick(3'b010, modelPtr);
        modelPtr = (w + 1) % NUM_REQ;
        req_inst_wvalid = 3'b010;
        msinst_wready   = 1'b1;
        @(negedge clk);
        msinst_execute_finish = 1'b1;
        #1;
        assertCount++;
        if (msinst_wvalid !== 1'b1 || req_execute_finish !== (NUM_REQ'(1) << w)) begin
            failCount++;
            $display("[TB] FAIL hs_finish_issue: got wvalid=%b fin=%b expected 1/%b", msinst_wvalid,
                     req_execute_finish, NUM_REQ'(1) << w);
        end
        @(negedge clk);
        req_inst_wvalid       = '0;
        msinst_wready         = 1'b0;
        msinst_execute_finish = 1'b0;
        #1;
        assertCount++;
        if (arb_active !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL hs_finish_idle: arb_active got %b expected 0", arb_active);
        end
    endtask

    task automatic test_reset_in_exec();
        int w;
        doReset();
        startTransaction(3'b001, 1'b0, w);
        msinst_busy          = 1'b1;
        msload_row_wvalid    = 1'b1;
        msstore_row_rvalid   = 1'b1;
        req_load_row_wready  = '1;
        req_store_row_rready = '1;
        @(negedge clk);
        rstnn = 1'b1;
        @(negedge clk);
        #1;
        assertCount++;
        if (outBus !== '0 || arb_active !== 1'b0 || grant_id !== 2'd0) begin
            failCount++;
            $display("[TB] FAIL exec_reset: got out=%h active=%b grant=%0d expected 0", outBus,
                     arb_active, grant_id);
        end
        rstnn                = 1'b0;
        modelPtr             = 0;
        msinst_busy          = 1'b0;
        msload_row_wvalid    = 1'b0;
        msstore_row_rvalid   = 1'b0;
        req_load_row_wready  = '0;
        req_store_row_rready = '0;
        startTransaction(3'b011, 1'b0, w);
        endTransaction();
        req_inst_wvalid = '0;
    endtask

`ifdef DCA_MLSU_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int w;
        int riseAt;
        doReset();
        startTransaction(3'b011, 1'b0, w);
        riseAt = -1;
        for (int n = 1; n <= 40 && riseAt < 0; n++) begin
            @(negedge clk);
            #1;
            if (wdog_error === 1'b1) riseAt = n;
        end
        assertCount++;
        if (riseAt != WDOG_CYCLES || arb_active !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL wdog_rise: got cycle %0d active=%b expected %0d/0", riseAt, arb_active,
                     WDOG_CYCLES);
        end
        startTransaction(req_inst_wvalid, 1'b0, w);
        assertCount++;
        if (wdog_error !== 1'b1 || grant_id !== 2'd1) begin
            failCount++;
            $display("[TB] FAIL wdog_next: got err=%b grant=%0d expected 1/1", wdog_error, grant_id);
        end
        endTransaction();
    endtask
`endif

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rstnn = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) curInst[i] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_load_rows();
        test_store_rows();
        test_finish_in_handshake();
        test_reset_in_exec();
`ifdef DCA_MLSU_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
